// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Shares one iterative 32-bit divider between two requesters:
//   port 0 : EX-stage DIV/DIVU path
//   port 1 : multi-cycle MADD/MSUB/HILO-assist path
// Requests are arbitrated round-robin. The winner's operands are latched and
// presented to the divider, and the {remainder, quotient} result goes back to
// the owner with a one-cycle done pulse. An owner flush or a watchdog timeout
// annuls the divider instead. Every completion or abort is followed by a
// QUIET-cycle release window before the next grant.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_i[1:0]        per-requester request, held until done or flush
//   signed_i[1:0]     per-requester signed (DIV) / unsigned (DIVU)
//   op1_x_i, op2_x_i  requester x dividend / divisor
//   flush_i[1:0]      per-requester cancel
//   gnt_o[1:0]        one-hot owner, valid in BUSY and RESULT
//   done_o[1:0]       one-cycle completion pulse to the owner
//   result_o[63:0]    {remainder, quotient}, valid with done_o
//   dz_o              divide-by-zero flag, valid with done_o
//   err_o             one-cycle watchdog timeout pulse
//   busy_o            high whenever the arbiter is not idle
//   div_*_o           operands and start/annul controls to the divider
//   div_result_i      {remainder, quotient} from the divider
//   div_ready_i       divider completion strobe
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int TIMEOUT = 48,
    parameter int QUIET   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [1:0]  signed_i,
    input  logic [31:0] op1_0_i,
    input  logic [31:0] op2_0_i,
    input  logic [31:0] op1_1_i,
    input  logic [31:0] op2_1_i,
    input  logic [1:0]  flush_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [63:0] result_o,
    output logic        dz_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    // One counter serves both as the BUSY watchdog and the RELEASE timer.
    localparam int CW = $clog2(TIMEOUT + QUIET + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESULT, RELEASE} state_t;

    state_t        state;
    logic          last_gnt;
    logic          dz;
    logic [CW-1:0] cnt;

    logic [1:0]    valid;
    logic          pick;
    logic          owner_flush;
    logic          ready_ok;
    logic          timed_out;

    // Arbitration and BUSY-state event decode. A flushing requester is never
    // a candidate, and a tie goes to whoever did not win last time. Ready is
    // masked in the first BUSY cycle (cnt == 0) so a stale strobe left over
    // from the previous operation cannot complete the new one.
    always_comb begin
        valid       = req_i & ~flush_i;
        pick        = 1'b0;
        if (valid == 2'b10) begin
            pick = 1'b1;
        end else if (valid == 2'b11) begin
            pick = ~last_gnt;
        end
        owner_flush = |(flush_i & gnt_o);
        ready_ok    = div_ready_i && (cnt != '0);
        timed_out   = (cnt == CW'(TIMEOUT - 1));
    end

    assign busy_o = (state != IDLE);

    // Main sequencer. All outputs are registered so they change only on the
    // clock edge, except under reset where they drop immediately. Pulsed
    // outputs (done, err, annul, dz) default low every cycle. Abort priority
    // in BUSY is owner flush, then ready, then timeout; a timeout only raises
    // err when no flush caused the abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last_gnt     <= 1'b1;
            dz           <= 1'b0;
            cnt          <= '0;
            gnt_o        <= 2'b00;
            done_o       <= 2'b00;
            result_o     <= '0;
            dz_o         <= 1'b0;
            err_o        <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
        end else begin
            done_o      <= 2'b00;
            err_o       <= 1'b0;
            div_annul_o <= 1'b0;
            dz_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid != 2'b00) begin
                        state        <= BUSY;
                        gnt_o        <= pick ? 2'b10 : 2'b01;
                        last_gnt     <= pick;
                        div_signed_o <= signed_i[pick];
                        div_op1_o    <= pick ? op1_1_i : op1_0_i;
                        div_op2_o    <= pick ? op2_1_i : op2_0_i;
                        dz           <= pick ? (op2_1_i == '0) : (op2_0_i == '0);
                        cnt          <= '0;
                        div_start_o  <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (owner_flush || (!ready_ok && timed_out)) begin
                        state        <= RELEASE;
                        err_o        <= ~owner_flush;
                        div_annul_o  <= 1'b1;
                        div_start_o  <= 1'b0;
                        gnt_o        <= 2'b00;
                        div_signed_o <= 1'b0;
                        div_op1_o    <= '0;
                        div_op2_o    <= '0;
                        cnt          <= '0;
                    end else if (ready_ok) begin
                        state       <= RESULT;
                        result_o    <= div_result_i;
                        done_o      <= gnt_o;
                        dz_o        <= dz;
                        div_start_o <= 1'b0;
                    end
                end
                RESULT: begin
                    state        <= RELEASE;
                    gnt_o        <= 2'b00;
                    div_signed_o <= 1'b0;
                    div_op1_o    <= '0;
                    div_op2_o    <= '0;
                    cnt          <= '0;
                end
                RELEASE: begin
                    if (cnt == CW'(QUIET - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
